// File: rtl/flex_counter_ud.sv
// flex_counter_ud: parametrised up/down counter with a programmable upper
// bound, synchronous clear/load, wrap or saturate at the ends of the range,
// registered terminal-count flags and a registered one-cycle wrap pulse.
module flex_counter_ud #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    up_down,
  input  logic                    sat_mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    zero_flag,
  output logic                    wrap_pulse
);

  localparam int N = NUM_CNT_BITS;

  // Registered state
  logic [N-1:0] r_count;
  logic         r_rollover;
  logic         r_zero;
  logic         r_wrap;

  // Combinational next-state terms
  logic [N-1:0] w_count_next;
  logic         w_wrap_next;
  logic         w_at_top;
  logic         w_at_zero;
  logic         w_above_top;
  logic [N-1:0] w_load_clamped;
  logic [N-1:0] w_inc;
  logic [N-1:0] w_dec;

  // Range comparisons are made against rollover_val, never 2^N-1. The +1 and
  // -1 results are only selected when the count is strictly inside the range,
  // so neither can overflow or underflow N bits.
  assign w_at_top       = (r_count == rollover_val);
  assign w_at_zero      = (r_count == '0);
  assign w_above_top    = (r_count > rollover_val);
  assign w_load_clamped = (load_val > rollover_val) ? rollover_val : load_val;
  assign w_inc          = r_count + {{(N-1){1'b0}}, 1'b1};
  assign w_dec          = r_count - {{(N-1){1'b0}}, 1'b1};

  // Next count and wrap detection; priority clear > load > enable > hold
  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (clear) begin
      w_count_next = '0;
    end else if (load) begin
      w_count_next = w_load_clamped;
    end else if (count_enable) begin
      if (up_down) begin
        if (w_above_top) begin
          // Bound was lowered beneath the count: re-enter the range
          w_count_next = sat_mode ? rollover_val : '0;
          w_wrap_next  = ~sat_mode;
        end else if (w_at_top) begin
          w_count_next = sat_mode ? r_count : '0;
          w_wrap_next  = ~sat_mode;
        end else begin
          w_count_next = w_inc;
        end
      end else begin
        if (w_above_top) begin
          // Stepping down from above the bound lands on it, silently
          w_count_next = rollover_val;
        end else if (w_at_zero) begin
          w_count_next = sat_mode ? r_count : rollover_val;
          w_wrap_next  = ~sat_mode;
        end else begin
          w_count_next = w_dec;
        end
      end
    end
  end

  // State and flag registers; flags describe the count they are stored with
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count    <= '0;
      r_zero     <= 1'b1;
      r_rollover <= (rollover_val == '0);
      r_wrap     <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_zero     <= (w_count_next == '0);
      r_rollover <= (w_count_next == rollover_val);
      r_wrap     <= w_wrap_next;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_rollover;
  assign zero_flag     = r_zero;
  assign wrap_pulse    = r_wrap;

endmodule
